// File: rtl/pc_target_table.sv
// pc_target_table: runtime-writable branch-target table plus fetch-stage program counter
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   stall               hold the PC this cycle (drops a concurrent jump)
//   jump_en, how_high   take the branch held at table index how_high
//   wr_en, wr_addr,
//   wr_data, wr_abs     write {wr_abs, wr_data} into entry wr_addr
//   target, target_abs  combinational contents of entry how_high
//   prog_ctr            registered program counter
//   jumped              registered, high for one cycle after a taken redirect
// Optional feature: define PC_TARGET_TABLE_BYPASS_EN to forward a same-cycle write to the lookup.
module pc_target_table #(
    parameter int D       = 12,
    parameter int ENTRIES = 8,
    parameter int IW      = $clog2(ENTRIES)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          stall,
    input  logic          jump_en,
    input  logic [IW-1:0] how_high,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [D-1:0]  wr_data,
    input  logic          wr_abs,
    output logic [D-1:0]  target,
    output logic          target_abs,
    output logic [D-1:0]  prog_ctr,
    output logic          jumped
);
    localparam logic [IW:0] N = (IW+1)'(ENTRIES);
    // Storage is padded to a power of two so any index is in range; the
    // padding is never written or read and is trimmed by synthesis.
    logic [D-1:0] val_q [2**IW];
    logic         abs_q [2**IW];
    logic         rd_ok, wr_ok, fwd;
    logic [D-1:0] pc_d;
    assign rd_ok = {1'b0, how_high} < N;
    assign wr_ok = {1'b0, wr_addr} < N;
`ifdef PC_TARGET_TABLE_BYPASS_EN
    assign fwd = wr_en & wr_ok & (wr_addr == how_high);
`else
    assign fwd = 1'b0;
`endif
    // Invalid indices read relative +1 so a stray jump just falls through.
    always_comb begin
        target     = fwd ? wr_data : rd_ok ? val_q[how_high] : D'(1);
        target_abs = fwd ? wr_abs  : rd_ok ? abs_q[how_high] : 1'b0;
        pc_d       = stall ? prog_ctr : jump_en ? (target_abs ? target : prog_ctr + target) : prog_ctr + D'(1);
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 2**IW; i++) begin
                val_q[i] <= D'(1);
                abs_q[i] <= 1'b0;
            end
            prog_ctr <= '0;
            jumped   <= 1'b0;
        end else begin
            if (wr_en && wr_ok) begin
                val_q[wr_addr] <= wr_data;
                abs_q[wr_addr] <= wr_abs;
            end
            prog_ctr <= pc_d;
            jumped   <= jump_en & ~stall;
        end
    end
endmodule

// File: doc/pc_target_table.md
# pc_target_table

Programmable branch-target table and program-counter register for the 9-bit CPU fetch stage. It holds `ENTRIES` runtime-writable jump targets, each either a signed PC-relative offset or an absolute address. Each cycle it advances, holds, or redirects the `D`-bit program counter. It is the fetch-stage successor to the fixed combinational target lookup: loop targets are loaded by the loader/host instead of being hard-coded.

## Interface
- `D`, default 12: program counter and target width in bits.
- `ENTRIES`, default 8: number of table entries, minimum 2; need not be a power of two.
- `IW`, default `$clog2(ENTRIES)`: index width; derived, do not override.
- `Clk`  in  1: single clock; all state updates on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold the PC this cycle.
- `jump_en`  in  1: take the branch selected by `how_high`.
- `how_high`  in  IW: table index used for lookup.
- `wr_en`  in  1: table write strobe.
- `wr_addr`  in  IW: table write index.
- `wr_data`  in  D: target value; two's-complement offset when relative.
- `wr_abs`  in  1: 1 = absolute address, 0 = PC-relative offset.
- `target`  out  D: combinational value of the selected entry.
- `target_abs`  out  1: combinational mode bit of the selected entry.
- `prog_ctr`  out  D: registered program counter.
- `jumped`  out  1: registered; 1 for one cycle after a redirect is taken.

## Operation
- The table has `ENTRIES` registers. Each holds a `{abs, value[D-1:0]}` pair.
- Reset behaviour:
  - Every entry is loaded with `{0, 1}`, i.e. relative +1, so an unprogrammed jump falls through.
  - `prog_ctr` = 0 and `jumped` = 0.
  - Writes presented during reset are discarded.
- Write: when `wr_en` is high and `wr_addr < ENTRIES`, the entry is updated at the clock edge. A write to an index `>= ENTRIES` is ignored.
- Lookup: `target` and `target_abs` show the entry at `how_high`. An index `>= ENTRIES` reads `{0, 1}`.
- Next-PC priority, highest first:
  1. `Reset` sets the PC to 0.
  2. `stall` holds the PC. A concurrent `jump_en` is dropped, not queued.
  3. `jump_en` with an absolute entry loads `value`.
  4. `jump_en` with a relative entry loads `prog_ctr + value`, modulo 2^D. A negative offset is the two's-complement `D`-bit value, and wrap-around is silent in both directions.
  5. Otherwise the PC is `prog_ctr + 1`, modulo 2^D, so 2^D−1 wraps to 0.
- `jumped` is registered as `jump_en & ~stall & ~Reset`.

## Timing
- Lookup is combinational: `how_high` to `target` in zero cycles.
- Redirect latency is 1: the PC value appears on `prog_ctr` the cycle after `jump_en` is sampled.
- Write-to-read latency is 1 cycle by default; see Configuration.
- Reset asserted mid-program takes effect at the next edge and overrides `stall`, `jump_en` and `wr_en` in the same cycle.
- A write and a jump to the same index in one cycle: the jump uses the value selected by Configuration; the write still lands.

## Configuration
- Macro `PC_TARGET_TABLE_BYPASS_EN`.
- Defined: same-cycle forwarding is on. When `wr_en` is high, `wr_addr == how_high` and the index is valid, `target` and `target_abs` show `wr_data` and `wr_abs`, and a concurrent jump uses the new value.
- Undefined: no forwarding. Lookup and jump use the stored (old) entry, and the new value is visible from the next cycle.

## Test plan
- Reset then 5 idle cycles, D=12: `prog_ctr` steps 0,1,2,3,4,5; `jumped` stays 0. Jump to any unprogrammed entry: PC+1.
- Write entry 3 = relative −41 (`0xFD7`). At PC=100, pulse `jump_en` with `how_high=3`: next `prog_ctr`=59 and `jumped`=1 for exactly one cycle. At PC=10 the same jump gives 4065, showing wrap.
- Write entry 6 = absolute 398. At PC=7, jump index 6: `prog_ctr`=398. Assert `stall` together with the jump: PC stays 7 and `jumped`=0.
- With `ENTRIES`=6, write index 7 = 500, then jump index 7 at PC=20: `target`=1 and the PC goes to 21.
- At PC=50, in one cycle, write entry 2 = absolute 200 and jump index 2 (entry previously relative +1):
  - With the macro: PC=200.
  - Without the macro: PC=51; a second jump to index 2 then gives 200.
- Assert `Reset` during a stall with `jump_en` and `wr_en` high: the next edge gives `prog_ctr`=0, the table is unchanged from reset defaults, and `jumped`=0.
